// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory port arbiter.
// The state enumeration is used by the top level and by anything that probes it.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DBG  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    localparam int          DEF_DATA_W    = 32;
    localparam int          DEF_AW        = 16;
    localparam logic [15:0] DEF_DUMP_BASE = 16'd64;
    localparam int          DEF_DUMP_LEN  = 16;

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter 0..DWELL-1; tick marks the last count of a dwell period.
// clr wins over en so the owner can restart the period on any cycle.
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == CW'(DWELL - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single dmem port between the core, a manual debug reader and a
// post-halt result dump that walks DUMP_LEN words from DUMP_BASE for display.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int             DATA_W    = DEF_DATA_W,
    parameter int             AW        = DEF_AW,
    parameter logic [AW-1:0]  DUMP_BASE = AW'(DEF_DUMP_BASE),
    parameter int             DUMP_LEN  = DEF_DUMP_LEN,
    parameter int             DWELL     = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     core_addr,
    input  logic [DATA_W-1:0] core_wd,
    input  logic              core_we,
    input  logic              core_finish,
    input  logic              dbg_en,
    input  logic [AW-1:0]     dbg_addr,
    input  logic              step,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [AW-1:0]     mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic [DATA_W-1:0] core_rd,
    output logic              core_stall,
    output logic [DATA_W-1:0] show_data,
    output logic [AW-1:0]     show_addr,
    output logic              show_valid,
    output logic              dump_done
);

    arb_state_e        state_q, state_d, mux_state;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] show_data_q, show_data_d;
    logic [AW-1:0]     show_addr_q, show_addr_d;
    logic              show_valid_q, show_valid_d;
    logic              dwell_tick;
    logic              advance;
    logic [AW-1:0]     dump_a;

    // Port muxing falls back to the core while reset is held.
    assign mux_state = rst_n ? state_q : ST_RUN;
    assign advance   = (state_q == ST_DUMP) && (dwell_tick || step);
    assign dump_a    = DUMP_BASE + idx_q;

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != ST_DUMP) || advance),
        .en    (state_q == ST_DUMP),
        .tick  (dwell_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            idx_q        <= '0;
            show_data_q  <= '0;
            show_addr_q  <= '0;
            show_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            show_data_q  <= show_data_d;
            show_addr_q  <= show_addr_d;
            show_valid_q <= show_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_RUN: begin
                idx_d = '0;
                if (dbg_en)           state_d = ST_DBG;
                else if (core_finish) state_d = ST_DUMP;
            end
            ST_DBG: begin
                idx_d = '0;
                if (!dbg_en) state_d = core_finish ? ST_DUMP : ST_RUN;
            end
            ST_DUMP: begin
                if (advance) begin
                    if (idx_q == AW'(DUMP_LEN - 1)) state_d = ST_DONE;
                    else                            idx_d   = idx_q + 1'b1;
                end
                if (dbg_en) state_d = ST_DBG;
            end
            ST_DONE: begin
                if (dbg_en) begin
                    state_d = ST_DBG;
                end else if (step) begin
                    state_d = ST_DUMP;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        mem_wd     = core_wd;
        core_rd    = mem_rd;
        mem_we     = 1'b0;
        core_stall = (mux_state != ST_RUN);
        dump_done  = (mux_state == ST_DONE);
        unique case (mux_state)
            ST_RUN: begin
                mem_a  = core_addr;
                mem_we = core_we;
            end
            ST_DBG:  mem_a = dbg_addr;
            default: mem_a = dump_a;
        endcase
    end

    // Debug mode shadows the addressed word continuously; dump captures only on advance.
    always_comb begin
        show_data_d  = show_data_q;
        show_addr_d  = show_addr_q;
        show_valid_d = advance;
        if (state_q == ST_DBG) begin
            show_data_d = mem_rd;
            show_addr_d = dbg_addr;
        end else if (advance) begin
            show_data_d = mem_rd;
            show_addr_d = mem_a;
        end
    end

    assign show_data  = show_data_q;
    assign show_addr  = show_addr_q;
    assign show_valid = show_valid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter with DWELL=4, DUMP_LEN=3: directed scenarios followed by
// random traffic, all checked cycle by cycle against a behavioural model of the arbiter.
module tb_dmem_port_arbiter;

    localparam int DWELL = 4;
    localparam int DLEN  = 3;
    localparam int BASE  = 64;
    localparam int M_RUN = 0, M_DBG = 1, M_DUMP = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] core_addr, dbg_addr;
    logic [31:0] core_wd;
    logic        core_we, core_finish, dbg_en, step;
    logic [31:0] mem_rd, mem_wd, core_rd, show_data;
    logic [15:0] mem_a, show_addr;
    logic        mem_we, core_stall, show_valid, dump_done;

    logic [31:0] dmem [0:65535];
    assign mem_rd = dmem[mem_a];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DWELL(DWELL), .DUMP_LEN(DLEN)) dut (
        .clk(clk), .rst_n(rst_n), .core_addr(core_addr), .core_wd(core_wd),
        .core_we(core_we), .core_finish(core_finish), .dbg_en(dbg_en),
        .dbg_addr(dbg_addr), .step(step), .mem_rd(mem_rd), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_we(mem_we), .core_rd(core_rd),
        .core_stall(core_stall), .show_data(show_data), .show_addr(show_addr),
        .show_valid(show_valid), .dump_done(dump_done)
    );

    // Behavioural model: mode, dump word position, cycles spent on that word, display regs.
    int          m_mode, m_pos, m_wait;
    logic [31:0] m_sd;
    logic [15:0] m_sa;
    logic        m_sv;
    bit          warm;
    int          n_cmp, n_bad, cyc;
    logic [15:0] exp_q[$];
    logic [15:0] got_a[$];
    logic [31:0] got_d[$];
    int          got_c[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int          em;
        logic [15:0] ea, wa;
        logic [31:0] erd, wd;
        logic        wwe;
        #1;
        em = rst_n ? m_mode : M_RUN;
        case (em)
            M_RUN:   ea = core_addr;
            M_DBG:   ea = dbg_addr;
            default: ea = 16'(BASE + m_pos);
        endcase
        erd = dmem[ea];
        check("mem_a", 32'(mem_a), 32'(ea));
        check("mem_we", 32'(mem_we), 32'((em == M_RUN) && core_we));
        check("core_stall", 32'(core_stall), 32'(em != M_RUN));
        check("core_rd", core_rd, erd);
        if (em == M_RUN) check("mem_wd", mem_wd, core_wd);
        if (warm) begin
            check("show_data", show_data, m_sd);
            check("show_addr", 32'(show_addr), 32'(m_sa));
            check("show_valid", 32'(show_valid), 32'(m_sv));
            check("dump_done", 32'(dump_done), 32'(em == M_DONE));
        end
        wwe = mem_we; wa = mem_a; wd = mem_wd;
        @(posedge clk);
        #1;
        cyc++;
        if (wwe) dmem[wa] = wd;
        if (!rst_n) begin
            m_mode = M_RUN; m_pos = 0; m_wait = 0;
            m_sd = '0; m_sa = '0; m_sv = 1'b0;
        end else begin
            m_sv = 1'b0;
            case (m_mode)
                M_RUN: begin
                    m_pos = 0; m_wait = 0;
                    if (dbg_en) m_mode = M_DBG;
                    else if (core_finish) m_mode = M_DUMP;
                end
                M_DBG: begin
                    m_sd = erd; m_sa = dbg_addr;
                    m_pos = 0; m_wait = 0;
                    if (!dbg_en) m_mode = core_finish ? M_DUMP : M_RUN;
                end
                M_DUMP: begin
                    if ((m_wait == DWELL - 1) || step) begin
                        m_sd = erd; m_sa = ea; m_sv = 1'b1; m_wait = 0;
                        if (m_pos == DLEN - 1) m_mode = M_DONE;
                        else m_pos++;
                    end else begin
                        m_wait++;
                    end
                    if (dbg_en) begin m_mode = M_DBG; m_wait = 0; end
                end
                default: begin
                    m_wait = 0;
                    if (dbg_en) m_mode = M_DBG;
                    else if (step) begin m_mode = M_DUMP; m_pos = 0; end
                end
            endcase
        end
        warm = 1'b1;
        if (show_valid) begin
            got_a.push_back(show_addr); got_d.push_back(show_data); got_c.push_back(cyc);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        got_a.delete(); got_d.delete(); got_c.delete(); exp_q.delete();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, 32'(got_a.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            check({tag, "_addr"}, 32'(got_a[i]), 32'(exp_q[i]));
            check({tag, "_data"}, got_d[i], 32'(exp_q[i] - 16'(BASE - 1)));
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; warm = 1'b0;
        m_mode = M_RUN; m_pos = 0; m_wait = 0; m_sd = '0; m_sa = '0; m_sv = 1'b0;
        for (int i = 0; i < 65536; i++) dmem[i] = $urandom;
        for (int i = 0; i < DLEN; i++) dmem[BASE + i] = 32'(i + 1);
        rst_n = 1'b0; core_addr = 16'd0; core_wd = '0; core_we = 1'b0;
        core_finish = 1'b0; dbg_en = 1'b0; dbg_addr = 16'd65; step = 1'b0;
        run(2);
        check("reset_stall", 32'(core_stall), 32'd0);
        check("reset_show_valid", 32'(show_valid), 32'd0);
        rst_n = 1'b1;

        // Core write in RUN
        core_addr = 16'd5; core_wd = 32'hA5; core_we = 1'b1;
        run(1);
        check("dmem5", dmem[5], 32'hA5);

        // Debug takeover while the core keeps writing
        dbg_en = 1'b1; dbg_addr = 16'd66;
        run(1);
        check("dbg_stall", 32'(core_stall), 32'd1);
        check("dbg_we", 32'(mem_we), 32'd0);
        check("dbg_a", 32'(mem_a), 32'd66);
        run(2);
        dbg_en = 1'b0; core_we = 1'b0;
        run(1);
        check("dbg_exit_stall", 32'(core_stall), 32'd0);

        // Full dump on halt
        clear_log();
        core_finish = 1'b1;
        run(14);
        exp_q = '{16'd64, 16'd65, 16'd66};
        check_log("dump");
        if (got_c.size() == 3) begin
            check("gap1", 32'(got_c[1] - got_c[0]), 32'd4);
            check("gap2", 32'(got_c[2] - got_c[1]), 32'd4);
        end
        check("dump_done", 32'(dump_done), 32'd1);

        // Restart from DONE, early step at dwell count 1, then reset mid-dump at idx 1
        step = 1'b1; run(1); step = 1'b0;
        clear_log();
        run(1);
        step = 1'b1; run(1); step = 1'b0;
        exp_q = '{16'd64};
        check_log("early_step");
        rst_n = 1'b0; run(1); rst_n = 1'b1;
        check("rst_valid", 32'(show_valid), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_data", show_data, 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);

        // Halt and debug together: debug wins, then dump restarts at the base
        core_finish = 1'b1; dbg_en = 1'b1; dbg_addr = 16'd3;
        run(1);
        check("prio_stall", 32'(core_stall), 32'd1);
        check("prio_a", 32'(mem_a), 32'd3);
        dbg_en = 1'b0;
        clear_log();
        run(4);
        // Fourth dwell count plus step counts once
        step = 1'b1; run(1); step = 1'b0;
        run(4);
        exp_q = '{16'd64, 16'd65};
        check_log("coincide");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            dbg_en      = ($urandom_range(0, 11) == 0);
            core_finish = ($urandom_range(0, 3) == 0);
            step        = ($urandom_range(0, 5) == 0);
            core_we     = $urandom_range(0, 1) == 1;
            core_addr   = 16'($urandom_range(0, 127));
            core_wd     = $urandom;
            dbg_addr    = 16'($urandom_range(60, 70));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning), SHALL be provided:
  DATA_W, 32, data width;
  AW, 16, dmem word-address width;
  DUMP_BASE, 16'd64, first result word;
  DUMP_LEN, 16, words per dump;
  DWELL, 50_000_000, cycles per dumped word.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  single clock;
  rst_n  in  1  synchronous, active-low reset;
  core_addr  in  AW  core data word address;
  core_wd  in  DATA_W  core write data;
  core_we  in  1  core write enable;
  core_finish  in  1  core halted;
  dbg_en  in  1  manual debug ownership request;
  dbg_addr  in  AW  manual word address;
  step  in  1  one-cycle advance pulse;
  mem_rd  in  DATA_W  dmem asynchronous read data;
  mem_a  out  AW  dmem word address;
  mem_wd  out  DATA_W  dmem write data;
  mem_we  out  1  dmem write enable;
  core_rd  out  DATA_W  read data to core;
  core_stall  out  1  core not granted;
  show_data  out  DATA_W  captured word for display;
  show_addr  out  AW  address of show_data;
  show_valid  out  1  one-cycle capture pulse;
  dump_done  out  1  dump complete.

Function
REQ-003 Registered state SHALL be one of RUN, DBG, DUMP, DONE; the block SHALL also hold a registered index idx (AW bits) and a dwell counter.
REQ-004 In RUN:
  - mem_a = core_addr, mem_wd = core_wd, mem_we = core_we;
  - core_stall = 0;
  - core_rd = mem_rd, combinational, same cycle.
REQ-005 In every other state:
  - core_stall = 1;
  - mem_we = 0, so core writes are dropped;
  - core_rd = mem_rd.
REQ-006 DBG:
  - mem_a = dbg_addr;
  - show_data <= mem_rd every cycle;
  - show_addr <= dbg_addr every cycle;
  - show_valid = 0.
REQ-007 DUMP:
  - mem_a = DUMP_BASE + idx, modulo 2^AW;
  - the dwell counter counts 0..DWELL-1.
REQ-008 A DUMP advance occurs on a cycle where the dwell counter equals DWELL-1, or where step = 1. Coincident dwell expiry and step SHALL count as a single advance. On each advance:
  - show_data <= mem_rd;
  - show_addr <= mem_a;
  - show_valid = 1 for the next cycle only;
  - the dwell counter clears.
REQ-009 On an advance with idx = DUMP_LEN-1, the state SHALL go to DONE with idx held; otherwise idx SHALL increment.
REQ-010 DONE:
  - dump_done = 1;
  - mem_a = DUMP_BASE + idx;
  - show_data is held.
  A step pulse in DONE SHALL clear idx and the dwell counter, deassert dump_done and enter DUMP.
REQ-011 Transitions out of RUN:
  - dbg_en = 1 -> DBG;
  - else core_finish = 1 -> DUMP, with idx = 0 and dwell = 0.
  dbg_en takes priority when both are asserted in the same cycle.
REQ-012 dbg_en = 1 in DUMP or DONE SHALL enter DBG on the next edge, abandoning the dump.
REQ-013 Leaving DBG on dbg_en = 0:
  - core_finish = 0 -> RUN;
  - core_finish = 1 -> DUMP, restarting at idx 0.
REQ-014 A step pulse in RUN or DBG SHALL be ignored.
REQ-015 All state changes SHALL take effect at the clk edge following the triggering input; output muxing SHALL follow the registered state.

Reset
REQ-016 On rst_n = 0 at a clk edge, the block SHALL set:
  - state RUN, idx 0, dwell 0;
  - show_data 0, show_addr 0;
  - show_valid 0, dump_done 0, core_stall 0.
  Reset SHALL take priority over every other input, including mid-dump and mid-debug.
REQ-017 While in reset, the RUN muxing SHALL still apply combinationally.

Structure
REQ-018 A shared package dmem_arb_pkg SHALL hold:
  - the state enumeration;
  - DATA_W, AW, DUMP_BASE and DUMP_LEN defaults.
REQ-019 The dwell counter SHALL be a sub-module dwell_timer with:
  - inputs clk, rst_n, clr, en;
  - output tick, asserted when count = DWELL-1.
REQ-020 No other sub-modules SHALL be used; the dmem itself SHALL remain external.

Verification (DWELL=4, DUMP_LEN=3)
REQ-021 Core write in RUN, core_addr=5, core_we=1, core_wd=0xA5 -> mem_we=1, mem_a=5, and dmem word 5 = 0xA5 after the edge.
REQ-022 dbg_en=1 while core_we=1 -> one cycle later core_stall=1, mem_we=0, mem_a=dbg_addr; dropping dbg_en with core_finish=0 -> RUN, core_stall=0.
REQ-023 core_finish=1 with dmem[64..66]=1,2,3 -> show_valid pulses 4 cycles apart, show_addr=64,65,66, show_data=1,2,3; then dump_done=1 and state DONE.
REQ-024 step pulse in DUMP at dwell count 1 -> immediate capture; a step coinciding with dwell expiry -> exactly one idx increment.
REQ-025 Same-cycle core_finish=1 and dbg_en=1 -> DBG; dbg_en then released -> DUMP starting at show_addr=64.
REQ-026 rst_n=0 mid-dump at idx=1 -> next cycle state RUN, show_valid=0, dump_done=0, show_data=0, core_stall=0.
